error_decoder: RTL and testbench
================================

ERROR_DECODER -- requirements
Module: error_decoder

Interface
REQ-001 Parameter DUTY_INIT, default 128, meaning duty value loaded on reset.
REQ-002 Parameter DUTY_MIN, default 16, meaning lower duty clamp; DUTY_MIN <= DUTY_INIT <= DUTY_MAX.
REQ-003 Parameter DUTY_MAX, default 240, meaning upper duty clamp.
REQ-004 Parameter UPDATE_DIV, default 4, range 1..16, meaning PWM periods per compensator update.
REQ-005 Parameter GAIN_SHIFT, default 0, range 0..3, meaning left shift applied to the decoded error.
REQ-006 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 en  input  4  two's-complement error code; valid range -4..+4; positive means output low, so duty increases.
REQ-009 pwm  output  1  registered DPWM gate drive.
REQ-010 duty  output  8  current compensator duty command, unsigned.
REQ-011 update  output  1  one-cycle pulse when duty is rewritten.
REQ-012 sat_hi, sat_lo  output  1 each  clamp-occurred flags for the last update.
REQ-013 code_err  output  1  last sampled en was outside -4..+4.

Function
REQ-014 Free-running 8-bit counter cnt SHALL increment every clk and wrap 255->0; the period is 256 clk.
REQ-015 duty_active SHALL load from duty only on cycles where cnt==255, giving a glitch-free shadow update.
REQ-016 pwm SHALL be registered as (cnt < duty_active); duty_active==0 gives constant low.
REQ-017 Period counter pcnt SHALL increment on cnt==255 and wrap at UPDATE_DIV-1 to 0.
REQ-018 The FSM SHALL have the states RUN, CALC, and CLAMP; reset state is RUN.
REQ-019 RUN->CALC SHALL occur at cycle T, where cnt==255 and pcnt==UPDATE_DIV-1; en SHALL be captured into en_q at that edge.
REQ-020 In CALC (T+1), the FSM SHALL register sum = duty + (sext(en_q) << GAIN_SHIFT) in 10-bit signed, then go to CLAMP.
REQ-021 Codes 0101..1011 SHALL be treated as 0, and code_err SHALL be set for that update.
REQ-022 In CLAMP (T+2), the clamp step SHALL compute duty <= min(max(sum, DUTY_MIN), DUTY_MAX), then return to RUN.
REQ-023 sat_hi SHALL be set if sum > DUTY_MAX, and sat_lo SHALL be set if sum < DUTY_MIN.
REQ-024 New duty, update=1, sat_hi, sat_lo and code_err SHALL all be visible at T+3; update SHALL deassert at T+4.
REQ-025 Flags SHALL hold until the next update rewrites them.
REQ-026 en SHALL be ignored on all cycles except T.
REQ-027 The new duty SHALL reach duty_active at the next cnt==255, one period after T.
REQ-028 A sum exactly equal to DUTY_MIN or DUTY_MAX SHALL NOT set a saturation flag.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set cnt=0, pcnt=0, duty=duty_active=DUTY_INIT, pwm=0, update=0, sat_hi=sat_lo=code_err=0, and FSM=RUN.
REQ-030 rst during CALC or CLAMP SHALL abort the update with no update pulse; rst SHALL take priority over all other events.

Verification
REQ-031 Reset, en=0000 held -> duty stays 128; pwm high 128 of every 256 clk; update pulses every 1024 clk; all flags 0.
REQ-032 en=0100 held -> duty steps 128,132,...,240 after 28 updates; the next update raises sat_hi=1 and duty stays 240.
REQ-033 GAIN_SHIFT=2, en=1100 held -> duty 128,112,96,80,...,16; at 16 the next sum is 0, so sat_lo=1 and duty stays 16.
REQ-034 en=1000 at cycle T -> code_err=1 at T+3, duty unchanged, update=1; the next valid code clears code_err.
REQ-035 en toggles 0001/1111 on every cycle except T, and en=0011 at T -> duty +3 only; the new duty is seen on pwm from the following period.
REQ-036 rst pulsed at T+1 -> no update pulse, duty=128, and cnt restarts at 0 on the following cycle.

Source files
------------

// File: rtl/error_decoder_if.sv
// error_decoder_if: error-code input and DPWM/compensator status outputs of error_decoder.
interface error_decoder_if;
    logic [3:0] en;
    logic       pwm;
    logic [7:0] duty;
    logic       update;
    logic       sat_hi;
    logic       sat_lo;
    logic       code_err;
    modport master (output en, input pwm, duty, update, sat_hi, sat_lo, code_err);
    modport slave  (input en, output pwm, duty, update, sat_hi, sat_lo, code_err);
endinterface

// File: rtl/error_decoder.sv
// error_decoder: decodes a 4-bit error code into a clamped duty update driving an 8-bit DPWM.
module error_decoder #(
    parameter int DUTY_INIT  = 128,
    parameter int DUTY_MIN   = 16,
    parameter int DUTY_MAX   = 240,
    parameter int UPDATE_DIV = 4,
    parameter int GAIN_SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    error_decoder_if.slave  bus
);
    typedef enum logic [1:0] {RUN, CALC, CLAMP} state_t;
    localparam logic signed [9:0] SMIN = 10'(DUTY_MIN);
    localparam logic signed [9:0] SMAX = 10'(DUTY_MAX);
    state_t            state;
    logic [7:0]        cnt;
    logic [7:0]        duty_active;
    logic [3:0]        pcnt;
    logic [3:0]        en_q;
    logic signed [9:0] sum;
    logic signed [9:0] en_ext;
    logic signed [9:0] err;
    logic              wrap;
    logic              last;
    logic              bad;
    assign wrap   = cnt == 8'd255;
    assign last   = pcnt == 4'(UPDATE_DIV - 1);
    // codes 5..11 lie outside -4..+4 and contribute nothing
    assign bad    = en_q >= 4'd5 && en_q <= 4'd11;
    assign en_ext = {{6{en_q[3]}}, en_q};
    assign err    = bad ? 10'sd0 : en_ext <<< GAIN_SHIFT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            pcnt         <= '0;
            duty_active  <= 8'(DUTY_INIT);
            en_q         <= '0;
            sum          <= '0;
            bus.duty     <= 8'(DUTY_INIT);
            bus.pwm      <= 1'b0;
            bus.update   <= 1'b0;
            bus.sat_hi   <= 1'b0;
            bus.sat_lo   <= 1'b0;
            bus.code_err <= 1'b0;
        end else begin
            cnt        <= cnt + 8'd1;
            bus.pwm    <= cnt < duty_active;
            bus.update <= 1'b0;
            if (wrap) begin
                duty_active <= bus.duty;
                pcnt        <= last ? 4'd0 : pcnt + 4'd1;
            end
            case (state)
                RUN: if (wrap && last) begin
                    en_q  <= bus.en;
                    state <= CALC;
                end
                CALC: begin
                    sum   <= $signed({2'b00, bus.duty}) + err;
                    state <= CLAMP;
                end
                CLAMP: begin
                    bus.duty     <= sum > SMAX ? 8'(DUTY_MAX) : sum < SMIN ? 8'(DUTY_MIN) : sum[7:0];
                    bus.sat_hi   <= sum > SMAX;
                    bus.sat_lo   <= sum < SMIN;
                    bus.code_err <= bad;
                    bus.update   <= 1'b1;
                    state        <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_error_decoder.sv
// tb_error_decoder: directed tests of duty stepping, clamping, code errors, PWM shadowing and reset abort.
module tb_error_decoder;
    logic clk;
    logic rst;
    logic rst2;
    int   tests;
    int   fails;
    int   to_t;
    error_decoder_if bus();
    error_decoder_if bus2();
    error_decoder dut (.clk(clk), .rst(rst), .bus(bus));
    error_decoder #(.GAIN_SHIFT(2), .UPDATE_DIV(1)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // walks dut up to and two edges past the capture edge T, with e_t present at T
    task automatic go(input logic [3:0] e_t, input bit tog);
        for (int i = 0; i < to_t - 1; i++) begin
            bus.en = tog ? (i[0] ? 4'b1111 : 4'b0001) : e_t;
            tick(1);
        end
        bus.en = e_t;
        tick(1);
        bus.en = tog ? 4'b1111 : e_t;
        tick(1);
        bus.en = tog ? 4'b0001 : e_t;
        tick(1);
        to_t = 1022;
    endtask

    task automatic test_reset;
        int c;
        rst = 1'b1;
        rst2 = 1'b1;
        bus.en = 4'b0000;
        bus2.en = 4'b0000;
        tick(2);
        rst = 1'b0;
        to_t = 1024;
        tests++;
        if (bus.duty !== 8'd128 || bus.pwm !== 1'b0 || bus.update !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs duty=%0d pwm=%b update=%b want 128 0 0", bus.duty, bus.pwm, bus.update);
        end
        tests++;
        if ({bus.sat_hi, bus.sat_lo, bus.code_err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000", {bus.sat_hi, bus.sat_lo, bus.code_err});
        end
        tests++;
        if (bus2.duty !== 8'd128) begin
            fails++;
            $display("FAIL reset_duty2 got %0d want 128", bus2.duty);
        end
        c = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            c += int'(bus.pwm);
        end
        to_t -= 256;
        tests++;
        if (c != 128) begin
            fails++;
            $display("FAIL pwm_high_count got %0d want 128", c);
        end
    endtask

    task automatic test_hold_zero;
        for (int k = 0; k < 3; k++) begin
            go(4'b0000, 1'b0);
            tests++;
            if (bus.update !== 1'b1 || bus.duty !== 8'd128 || {bus.sat_hi, bus.sat_lo, bus.code_err} !== 3'b000) begin
                fails++;
                $display("FAIL hold_zero[%0d] update=%b duty=%0d flags=%b want 1 128 000", k, bus.update, bus.duty,
                         {bus.sat_hi, bus.sat_lo, bus.code_err});
            end
            tick(1);
            to_t--;
            tests++;
            if (bus.update !== 1'b0) begin
                fails++;
                $display("FAIL hold_zero_fall[%0d] update=%b want 0", k, bus.update);
            end
        end
    endtask

    task automatic test_sat_hi;
        logic [7:0] d;
        for (int k = 1; k <= 29; k++) begin
            go(4'b0100, 1'b0);
            d = k <= 28 ? 8'(128 + 4 * k) : 8'd240;
            tests++;
            if (bus.update !== 1'b1 || bus.duty !== d || {bus.sat_hi, bus.sat_lo, bus.code_err} !== {k == 29, 2'b00}) begin
                fails++;
                $display("FAIL sat_hi_step[%0d] update=%b duty=%0d flags=%b want 1 %0d %b", k, bus.update, bus.duty,
                         {bus.sat_hi, bus.sat_lo, bus.code_err}, d, {k == 29, 2'b00});
            end
        end
        tick(1);
        to_t--;
        tests++;
        if (bus.update !== 1'b0 || bus.sat_hi !== 1'b1) begin
            fails++;
            $display("FAIL sat_hi_hold update=%b sat_hi=%b want 0 1", bus.update, bus.sat_hi);
        end
    endtask

    task automatic test_code_err;
        logic [3:0] codes [3];
        logic       want [3];
        codes = '{4'b1000, 4'b0101, 4'b0000};
        want  = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            go(codes[k], 1'b0);
            tests++;
            if (bus.update !== 1'b1 || bus.duty !== 8'd240 || {bus.sat_hi, bus.sat_lo, bus.code_err} !== {2'b00, want[k]}) begin
                fails++;
                $display("FAIL code_err[%0d] update=%b duty=%0d flags=%b want 1 240 %b", k, bus.update, bus.duty,
                         {bus.sat_hi, bus.sat_lo, bus.code_err}, {2'b00, want[k]});
            end
        end
    endtask

    task automatic test_toggle;
        int c;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        to_t = 1024;
        go(4'b0011, 1'b1);
        tests++;
        if (bus.update !== 1'b1 || bus.duty !== 8'd131 || {bus.sat_hi, bus.sat_lo, bus.code_err} !== 3'b000) begin
            fails++;
            $display("FAIL toggle_duty update=%b duty=%0d flags=%b want 1 131 000", bus.update, bus.duty,
                     {bus.sat_hi, bus.sat_lo, bus.code_err});
        end
        c = 0;
        for (int i = 0; i < 254; i++) begin
            tick(1);
            c += int'(bus.pwm);
        end
        tests++;
        if (c != 126) begin
            fails++;
            $display("FAIL toggle_old_period got %0d want 126", c);
        end
        c = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            c += int'(bus.pwm);
        end
        tests++;
        if (c != 131) begin
            fails++;
            $display("FAIL toggle_new_period got %0d want 131", c);
        end
        to_t -= 510;
    endtask

    task automatic test_rst_abort;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.en = 4'b0001;
        tick(1024);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++;
        if (bus.update !== 1'b0 || bus.duty !== 8'd128 || bus.pwm !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset update=%b duty=%0d pwm=%b want 0 128 0", bus.update, bus.duty, bus.pwm);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1);
            tests++;
            if (bus.update !== 1'b0 || bus.duty !== 8'd128) begin
                fails++;
                $display("FAIL abort_no_update[%0d] update=%b duty=%0d want 0 128", k, bus.update, bus.duty);
            end
        end
        to_t = 1022;
        go(4'b0001, 1'b0);
        tests++;
        if (bus.update !== 1'b1 || bus.duty !== 8'd129) begin
            fails++;
            $display("FAIL abort_restart update=%b duty=%0d want 1 129", bus.update, bus.duty);
        end
    endtask

    task automatic test_gain;
        int n;
        logic [7:0] d;
        bus2.en = 4'b1100;
        rst2 = 1'b1;
        tick(1);
        rst2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n = 0;
            while (bus2.update !== 1'b1 && n < 300) begin
                tick(1);
                n++;
            end
            d = k < 8 ? 8'(128 - 16 * k) : 8'd16;
            tests++;
            if (bus2.update !== 1'b1 || bus2.duty !== d || {bus2.sat_hi, bus2.sat_lo, bus2.code_err} !== {1'b0, k == 8, 1'b0}) begin
                fails++;
                $display("FAIL gain_step[%0d] update=%b duty=%0d flags=%b want 1 %0d %b", k, bus2.update, bus2.duty,
                         {bus2.sat_hi, bus2.sat_lo, bus2.code_err}, d, {1'b0, k == 8, 1'b0});
            end
            tick(1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        rst2 = 1'b1;
        bus.en = 4'b0000;
        bus2.en = 4'b0000;
        test_reset;
        test_hold_zero;
        test_sat_hi;
        test_code_err;
        test_toggle;
        test_rst_abort;
        test_gain;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
